// File: rtl/frag_pkg.sv
// ---------------------------------------------------------------------------
// frag_pkg: constants and types shared between the index sorter and the fetcher.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package frag_pkg;

  localparam int BYTE               = 8;
  localparam int COMPRESSION_FACTOR = 16;
  localparam int INDEX_LENGTH       = 2 * BYTE;

  typedef logic [INDEX_LENGTH-1:0] idx_t;
  typedef idx_t [COMPRESSION_FACTOR-1:0] idx_batch_t;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    SORT      = 2'd1,
    EMIT      = 2'd2,
    WAIT_DONE = 2'd3
  } sorter_state_t;

endpackage

`default_nettype wire

// File: rtl/idx_cmp_swap.sv
// ---------------------------------------------------------------------------
// idx_cmp_swap: combinational compare-exchange; IDX_SORTER_DESC_EN selects descending.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idx_cmp_swap
  import frag_pkg::*;
(
  input  logic [INDEX_LENGTH-1:0] a,
  input  logic [INDEX_LENGTH-1:0] b,
  output logic [INDEX_LENGTH-1:0] lo,
  output logic [INDEX_LENGTH-1:0] hi
);

  logic swap;

  // Strict compare so equal keys never move.
`ifdef IDX_SORTER_DESC_EN
  assign swap = (a < b);
`else
  assign swap = (a > b);
`endif

  assign lo = swap ? b : a;
  assign hi = swap ? a : b;

endmodule

`default_nettype wire

// File: rtl/idx_sorter.sv
// ---------------------------------------------------------------------------
// idx_sorter: batch collector plus odd-even transposition sort; IDX_SORTER_DESC_EN sorts descending.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idx_sorter
  import frag_pkg::*;
(
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic [INDEX_LENGTH-1:0]                        i_idx,
  input  logic                                           i_idx_valid,
  output logic                                           o_idx_ready,
  output logic [COMPRESSION_FACTOR-1:0][INDEX_LENGTH-1:0] o_idxs,
  output logic                                           o_idxs_ready,
  input  logic                                           i_done,
  output logic                                           o_busy
);

  localparam int CNT_W  = $clog2(COMPRESSION_FACTOR);
  localparam int PASS_W = CNT_W + 1;

  sorter_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [PASS_W-1:0] pass;
  idx_batch_t        idx;
  idx_batch_t        even_res;
  idx_batch_t        odd_res;

  for (genvar p = 0; p < COMPRESSION_FACTOR / 2; p++) begin : g_even
    idx_cmp_swap u_cs (
      .a  (idx[2*p]),
      .b  (idx[2*p+1]),
      .lo (even_res[2*p]),
      .hi (even_res[2*p+1])
    );
  end

  // Odd passes leave the two end elements untouched.
  assign odd_res[0]                    = idx[0];
  assign odd_res[COMPRESSION_FACTOR-1] = idx[COMPRESSION_FACTOR-1];

  for (genvar p = 0; p < COMPRESSION_FACTOR / 2 - 1; p++) begin : g_odd
    idx_cmp_swap u_cs (
      .a  (idx[2*p+1]),
      .b  (idx[2*p+2]),
      .lo (odd_res[2*p+1]),
      .hi (odd_res[2*p+2])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FILL;
      cnt   <= '0;
      pass  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (i_idx_valid) begin
            idx[cnt] <= i_idx;
            if (cnt == CNT_W'(COMPRESSION_FACTOR - 1)) begin
              cnt   <= '0;
              state <= SORT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SORT: begin
          idx <= pass[0] ? odd_res : even_res;
          if (pass == PASS_W'(COMPRESSION_FACTOR - 1)) begin
            pass  <= '0;
            state <= EMIT;
          end else begin
            pass <= pass + 1'b1;
          end
        end
        EMIT: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (i_done) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  assign o_idx_ready  = (state == FILL);
  assign o_idxs_ready = (state == EMIT);
  assign o_busy       = (state != FILL);
  assign o_idxs       = idx;

endmodule

`default_nettype wire

// File: tb/tb_idx_sorter.sv
// ---------------------------------------------------------------------------
// tb_idx_sorter: scoreboard bench for idx_sorter (handles IDX_SORTER_DESC_EN builds).
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_idx_sorter;
  import frag_pkg::*;

  localparam int CF = COMPRESSION_FACTOR;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  idx_t       i_idx = '0;
  logic       i_idx_valid = 1'b0;
  logic       o_idx_ready;
  idx_batch_t o_idxs;
  logic       o_idxs_ready;
  logic       i_done = 1'b0;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  idx_batch_t exp_q[$];

  always #5 clk = ~clk;

  idx_sorter dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_idx        (i_idx),
    .i_idx_valid  (i_idx_valid),
    .o_idx_ready  (o_idx_ready),
    .o_idxs       (o_idxs),
    .o_idxs_ready (o_idxs_ready),
    .i_done       (i_done),
    .o_busy       (o_busy)
  );

  function automatic idx_batch_t model_sort(input idx_batch_t b);
    idx_t t;
    for (int i = 0; i < CF; i++) begin
      for (int j = 0; j < CF - 1 - i; j++) begin
`ifdef IDX_SORTER_DESC_EN
        if (b[j] < b[j+1]) begin
`else
        if (b[j] > b[j+1]) begin
`endif
          t = b[j]; b[j] = b[j+1]; b[j+1] = t;
        end
      end
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_batch(input idx_batch_t vals, input bit push, input bit gap);
    if (push) exp_q.push_back(model_sort(vals));
    for (int i = 0; i < CF; i++) begin
      if (gap && i == 5) begin
        i_idx_valid = 1'b0;
        tick();
      end
      i_idx_valid = 1'b1;
      i_idx = vals[i];
      checks++;
      if (o_idx_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b expected 1", i, o_idx_ready);
      end
      tick();
    end
    i_idx_valid = 1'b0;
  endtask

  // Starts in the cycle right after the last accept; latency counted in cycles from it.
  task automatic wait_emit(input string name, input bit done_in_emit);
    int lat;
    bit found;
    idx_batch_t exp;
    lat = 1;
    found = 1'b0;
    while (lat < 40) begin
      if (o_idxs_ready === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_latency: no o_idxs_ready within %0d cycles, expected %0d", name, lat, CF + 1);
    end else if (lat != CF + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, CF + 1);
    end
    if (found) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_data: unexpected batch %h", name, o_idxs);
      end else begin
        exp = exp_q.pop_front();
        if (o_idxs !== exp) begin
          errors++;
          $display("FAIL %s_data: got %h expected %h", name, o_idxs, exp);
        end
      end
    end
    if (done_in_emit) i_done = 1'b1;
    tick();
    i_done = 1'b0;
    checks++;
    if (o_idxs_ready !== 1'b0 || o_busy !== 1'b1 || o_idx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_emit: ready_pulse=%b busy=%b idx_ready=%b expected 0/1/0",
               name, o_idxs_ready, o_busy, o_idx_ready);
    end
  endtask

  task automatic release_done(input string name);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    checks++;
    if (o_idx_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: idx_ready=%b busy=%b expected 1/0", name, o_idx_ready, o_busy);
    end
  endtask

  task automatic test_reset();
    idx_batch_t v;
    bit seen;
    rstn = 1'b0;
    #2;
    checks++;
    if (o_idx_ready !== 1'b1 || o_idxs_ready !== 1'b0 || o_busy !== 1'b0 || o_idxs !== '0) begin
      errors++;
      $display("FAIL reset_values: idx_ready=%b pulse=%b busy=%b idxs=%h expected 1/0/0/0",
               o_idx_ready, o_idxs_ready, o_busy, o_idxs);
    end
    @(posedge clk); #1 rstn = 1'b1;
    tick();
    for (int i = 0; i < CF; i++) v[i] = idx_t'(16'h0500 + i * 3);
    feed_batch(v, 1'b0, 1'b0);
    repeat (4) tick();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (o_idxs_ready !== 1'b0 || o_busy !== 1'b0 || o_idxs !== '0) begin
      errors++;
      $display("FAIL reset_mid_sort: pulse=%b busy=%b idxs=%h expected 0/0/0", o_idxs_ready, o_busy, o_idxs);
    end
    @(posedge clk); #1 rstn = 1'b1;
    tick();
    checks++;
    if (o_idx_ready !== 1'b1 || o_idxs !== '0) begin
      errors++;
      $display("FAIL reset_release: idx_ready=%b idxs=%h expected 1/0", o_idx_ready, o_idxs);
    end
    // Reset during the EMIT pulse must drop it without waiting for a clock edge.
    feed_batch(v, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (o_idxs_ready === 1'b1) seen = 1'b1;
      else tick();
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (!seen || o_idxs_ready !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_emit: seen=%b pulse=%b busy=%b expected 1/0/0", seen, o_idxs_ready, o_busy);
    end
    @(posedge clk); #1 rstn = 1'b1;
    tick();
  endtask

  task automatic test_reverse();
    idx_batch_t v;
    for (int i = 0; i < CF; i++) v[i] = idx_t'(CF - 1 - i);
    feed_batch(v, 1'b1, 1'b0);
    wait_emit("reverse", 1'b0);
    release_done("reverse");
  endtask

  task automatic test_duplicates();
    idx_batch_t v;
    for (int i = 0; i < CF; i++)
      v[i] = (i % 3 == 0) ? 16'hFFFF : ((i % 3 == 1) ? 16'h0000 : 16'h0100);
    feed_batch(v, 1'b1, 1'b1);
    wait_emit("duplicates", 1'b0);
    release_done("duplicates");
  endtask

  task automatic test_backpressure();
    idx_batch_t v;
    idx_batch_t exp;
    for (int i = 0; i < CF; i++) v[i] = idx_t'((i * 40503 + 77) & 16'hFFFF);
    exp = model_sort(v);
    feed_batch(v, 1'b1, 1'b0);
    i_idx_valid = 1'b1;
    i_idx = 16'hDEAD;
    checks++;
    if (o_idx_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_sort_ready: got %b expected 0", o_idx_ready);
    end
    wait_emit("backpressure", 1'b1);
    for (int i = 0; i < 5; i++) begin
      i_idx = idx_t'(16'hBEE0 + i);
      tick();
      checks++;
      if (o_idx_ready !== 1'b0 || o_busy !== 1'b1 || o_idxs !== exp) begin
        errors++;
        $display("FAIL bp_wait_hold[%0d]: idx_ready=%b busy=%b idxs=%h expected 0/1/%h",
                 i, o_idx_ready, o_busy, o_idxs, exp);
      end
    end
    i_idx_valid = 1'b0;
    release_done("backpressure");
  endtask

  task automatic test_back_to_back();
    idx_batch_t v;
    for (int i = 0; i < CF; i++) v[i] = idx_t'(1000 + ((i * 7) % CF));
    feed_batch(v, 1'b1, 1'b0);
    wait_emit("b2b_first", 1'b0);
    release_done("b2b_first");
    for (int i = 0; i < CF; i++) v[i] = idx_t'(1000 + ((i * 5 + 3) % CF));
    feed_batch(v, 1'b1, 1'b0);
    wait_emit("b2b_second", 1'b0);
    release_done("b2b_second");
  endtask

  task automatic test_ordered_input();
    idx_batch_t v;
    for (int i = 0; i < CF; i++) v[i] = idx_t'(i);
    feed_batch(v, 1'b1, 1'b0);
    wait_emit("ordered", 1'b0);
    release_done("ordered");
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_duplicates();
    test_backpressure();
    test_back_to_back();
    test_ordered_input();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d batches never emitted", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
